tape_stream_reader: RTL

- Downstream consumer of the structural tape RAM.
- After the parser finishes, it reads a contiguous range of 64-bit tape words from one BlockRam read port and emits them in order on a valid/ready stream toward the host-side DMA/serializer.
- Hides the fixed RAM read latency with a credit-limited prefetch FIFO, so the output sustains one word per cycle while ready stays high.

---
 rtl/tape_stream_reader_pkg.sv | 30 +++
 rtl/tape_stream_reader_prefetch_fifo.sv | 78 +++++++
 rtl/tape_stream_reader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/tape_stream_reader_pkg.sv
// ============================================================================
// Module      : tape_stream_reader_pkg
// Description : Shared tape types and constants for the tape stream reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tape_stream_reader_pkg;

    localparam int STRUCT_TAPE_LENGTH   = 16384;
    localparam int TAPE_ADDR_WIDTH      = $clog2(STRUCT_TAPE_LENGTH);
    localparam int TAPE_WORD_WIDTH      = 64;
    localparam int DEFAULT_READ_LATENCY = 1;

    typedef logic [TAPE_WORD_WIDTH-1:0] tape_word_t;
    typedef logic [TAPE_ADDR_WIDTH-1:0] tape_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } reader_state_t;

    function automatic int fifo_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tape_stream_reader_prefetch_fifo.sv
// ============================================================================
// Module      : tape_prefetch_fifo
// Description : Synchronous FIFO holding prefetched tape words; head is
//               visible combinationally while not empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tape_prefetch_fifo
    import tape_stream_reader_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CNT_W = fifo_count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign w_pop = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));

    a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_no_underflow : assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

`default_nettype wire

// File: rtl/tape_stream_reader.sv
// ============================================================================
// Module      : tape_stream_reader
// Description : Streams a contiguous range of tape RAM words onto a
//               valid/ready interface through a credit-limited prefetch FIFO.
//               Optional stall counter port enabled by TAPE_STREAM_STALLCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tape_stream_reader
    import tape_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = TAPE_WORD_WIDTH,
    parameter int ADDR_WIDTH   = TAPE_ADDR_WIDTH,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY,
    parameter int FIFO_DEPTH   = READ_LATENCY + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
`ifdef TAPE_STREAM_STALLCNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int c_CNT_W = fifo_count_width(FIFO_DEPTH);
    localparam int c_OCC_W = $clog2(FIFO_DEPTH + READ_LATENCY + 2);

    reader_state_t           r_state;
    reader_state_t           w_next_state;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [ADDR_WIDTH:0]     r_length;
    logic [ADDR_WIDTH:0]     r_issued;
    logic [ADDR_WIDTH:0]     r_sent;
    logic [READ_LATENCY-1:0] r_rd_vld;

    logic                    w_accept;
    logic                    w_issue;
    logic [ADDR_WIDTH-1:0]   w_issue_addr;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_last_beat;
    logic                    w_credit;
    logic [c_OCC_W-1:0]      w_inflight;
    logic [c_OCC_W-1:0]      w_occupancy;
    logic [DATA_WIDTH-1:0]   w_fifo_head;
    logic [c_CNT_W-1:0]      w_fifo_count;
    logic                    w_fifo_empty;
    logic                    w_fifo_full;

    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_push      = r_rd_vld[READ_LATENCY-1];
    assign w_pop       = !w_fifo_empty && out_ready;
    assign w_last_beat = (r_sent == r_length - (ADDR_WIDTH + 1)'(1));

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + c_OCC_W'(r_rd_vld[i]);
        end
    end

    // The entry being popped this cycle frees its slot in time for a new
    // read, which is what lets the stream sustain one word per cycle.
    assign w_occupancy = w_inflight + c_OCC_W'(w_fifo_count) - c_OCC_W'(w_pop);
    assign w_credit    = (w_occupancy < c_OCC_W'(FIFO_DEPTH));

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_issue_addr = r_base + r_issued[ADDR_WIDTH-1:0];
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        w_next_state = ST_FINISH;
                    end else begin
                        // First read goes out in the start cycle; the
                        // pipeline is empty here so credit is implied.
                        w_next_state = ST_RUN;
                        w_issue      = 1'b1;
                        w_issue_addr = base_addr;
                    end
                end
            end
            ST_RUN: begin
                if ((r_issued < r_length) && w_credit) begin
                    w_issue = 1'b1;
                end
                if (w_pop && w_last_beat) begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_base   <= '0;
            r_length <= '0;
            r_issued <= '0;
            r_sent   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_base   <= base_addr;
                r_length <= length;
                r_issued <= (ADDR_WIDTH + 1)'(w_issue);
                r_sent   <= '0;
            end else if (r_state == ST_RUN) begin
                r_issued <= r_issued + (ADDR_WIDTH + 1)'(w_issue);
                r_sent   <= r_sent + (ADDR_WIDTH + 1)'(w_pop);
            end
        end
    end

    // Read-return tracker: a set bit at the tail marks ram_rdata as a live word.
    generate
        if (READ_LATENCY == 1) begin : g_vld_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_vld <= '0;
                end else begin
                    r_rd_vld <= w_issue;
                end
            end
        end else begin : g_vld_pipe
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_vld <= '0;
                end else begin
                    r_rd_vld <= {r_rd_vld[READ_LATENCY-2:0], w_issue};
                end
            end
        end
    endgenerate

    tape_prefetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (ram_rdata),
        .pop       (w_pop),
        .head      (w_fifo_head),
        .count     (w_fifo_count),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full)
    );

    a_credit_push : assert property (@(posedge clk) disable iff (rst) w_push |-> !w_fifo_full);

    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_FINISH);
    assign ram_en    = w_issue;
    assign ram_addr  = w_issue ? w_issue_addr : '0;
    assign out_valid = !w_fifo_empty;
    assign out_data  = w_fifo_empty ? '0 : w_fifo_head;
    assign out_last  = !w_fifo_empty && w_last_beat;

`ifdef TAPE_STREAM_STALLCNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

endmodule

`default_nettype wire
